// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_BITS = 7;
  localparam int unsigned I2C_BYTE_BITS = 8;
  localparam int unsigned I2C_CNT_BITS  = 3;

  localparam logic [I2C_ADDR_BITS-1:0] I2C_DEFAULT_ADDR = 7'h1A;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_SUB      = 3'd3,
    ST_SUB_ACK  = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  // ACK slot that follows a byte-receiving state
  function automatic state_t ack_of(input state_t s);
    case (s)
      ST_ADDR: ack_of = ST_ADDR_ACK;
      ST_SUB:  ack_of = ST_SUB_ACK;
      ST_DATA: ack_of = ST_DATA_ACK;
      default: ack_of = ST_IGNORE;
    endcase
  endfunction

  // State entered once an ACK slot ends
  function automatic state_t after_ack(input state_t s);
    case (s)
      ST_ADDR_ACK: after_ack = ST_SUB;
      ST_SUB_ACK:  after_ack = ST_DATA;
      default:     after_ack = ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with clock-edge and START/STOP event pulses.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_sync,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_h_q;
  logic                   sda_h_q;
  logic                   scl_s;
  logic                   sda_s;

  // Presetting to 1 models an idle bus so reset release never fakes an event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q   <= '1;
      sda_q   <= '1;
      scl_h_q <= 1'b1;
      sda_h_q <= 1'b1;
    end else begin
      scl_q   <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q   <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_h_q <= scl_s;
      sda_h_q <= sda_s;
    end
  end

  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign sda_sync = sda_s;

  assign scl_rise_c = scl_s & ~scl_h_q;
  assign scl_fall_c = ~scl_s & scl_h_q;

  // SCL must be high on both sides of the SDA edge
  assign start_c = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_c  = scl_s & scl_h_q & ~sda_h_q & sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: receives [addr+W, sub-addr, data], ACKs each byte and strobes the write.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_BITS-1:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
  parameter int unsigned              SYNC_STAGES = 2
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     I2C_SCLK,
  inout  wire                      I2C_SDAT,
  output logic [I2C_BYTE_BITS-1:0] REG_ADDR,
  output logic [I2C_BYTE_BITS-1:0] REG_DATA,
  output logic                     REG_WE,
  output logic                     BUSY,
  output logic                     ADDR_HIT
);

  localparam logic [I2C_CNT_BITS-1:0] LAST_BIT = I2C_CNT_BITS'(I2C_BYTE_BITS - 1);

  logic sda_s;
  logic scl_rise_c;
  logic scl_fall_c;
  logic start_c;
  logic stop_c;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (CLOCK),
    .rst_n     (RESET),
    .scl       (I2C_SCLK),
    .sda       (I2C_SDAT),
    .sda_sync  (sda_s),
    .scl_rise_c(scl_rise_c),
    .scl_fall_c(scl_fall_c),
    .start_c   (start_c),
    .stop_c    (stop_c)
  );

  state_t                     state_q, state_d;
  logic [I2C_CNT_BITS-1:0]    bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_BITS-2:0]   shift_q, shift_d;
  logic [I2C_BYTE_BITS-1:0]   sub_q, sub_d;
  logic                       ack_pend_q, ack_pend_d;
  logic [I2C_BYTE_BITS-1:0]   reg_addr_q, reg_addr_d;
  logic [I2C_BYTE_BITS-1:0]   reg_data_q, reg_data_d;
  logic                       reg_we_q, reg_we_d;
  logic                       busy_q, busy_d;
  logic                       hit_q, hit_d;
  logic                       drive_q, drive_d;

  logic [I2C_BYTE_BITS-1:0]   rx_byte_c;
  logic                       addr_ok_c;

  // Byte as it stands once the bit on the current rising edge is included
  assign rx_byte_c = {shift_q, sda_s};
  assign addr_ok_c = (rx_byte_c[I2C_BYTE_BITS-1:1] == SLAVE_ADDR) && !rx_byte_c[0];

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sub_q      <= '0;
      ack_pend_q <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      reg_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sub_q      <= sub_d;
      ack_pend_q <= ack_pend_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      reg_we_q   <= reg_we_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      drive_q    <= drive_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sub_d      = sub_q;
    ack_pend_d = ack_pend_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    reg_we_d   = 1'b0;
    busy_d     = busy_q;
    hit_d      = hit_q;
    drive_d    = drive_q;

    // Bus conditions override any SCL edge seen in the same cycle
    if (start_c) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = '0;
      ack_pend_d = 1'b0;
      busy_d     = 1'b1;
      hit_d      = 1'b0;
      drive_d    = 1'b0;
    end else if (stop_c) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      ack_pend_d = 1'b0;
      busy_d     = 1'b0;
      hit_d      = 1'b0;
      drive_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_SUB, ST_DATA: begin
          if (ack_pend_q) begin
            // Byte complete: pull SDA low once SCL has gone low
            if (scl_fall_c) begin
              ack_pend_d = 1'b0;
              drive_d    = 1'b1;
              state_d    = ack_of(state_q);
              if (state_q == ST_ADDR) hit_d = 1'b1;
            end
          end else if (scl_rise_c) begin
            shift_d   = rx_byte_c[I2C_BYTE_BITS-2:0];
            bit_cnt_d = bit_cnt_q + I2C_CNT_BITS'(1);
            if (bit_cnt_q == LAST_BIT) begin
              ack_pend_d = 1'b1;
              case (state_q)
                ST_ADDR: begin
                  if (!addr_ok_c) begin
                    ack_pend_d = 1'b0;
                    state_d    = ST_IGNORE;
                  end
                end
                ST_SUB: sub_d = rx_byte_c;
                default: begin
                  reg_addr_d = sub_q;
                  reg_data_d = rx_byte_c;
                  reg_we_d   = 1'b1;
                end
              endcase
            end
          end
        end
        ST_ADDR_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
          // ACK held through the high phase; release on the closing fall
          if (scl_fall_c) begin
            drive_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = after_ack(state_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign I2C_SDAT = drive_q ? 1'b0 : 1'bz;

  assign REG_ADDR = reg_addr_q;
  assign REG_DATA = reg_data_q;
  assign REG_WE   = reg_we_q;
  assign BUSY     = busy_q;
  assign ADDR_HIT = hit_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bus master tasks, per-scenario checks, transaction-level reference model.
module tb_i2c_slave_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       tb_rel;
  wire        sda_bus;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_we;
  logic       busy;
  logic       addr_hit;

  int n_checks = 0;
  int n_pass   = 0;

  int we_cycles = 0;
  int we_pulses = 0;
  int spur_low  = 0;
  logic we_prev = 1'b0;

  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_data = 8'h00;

  localparam logic [6:0] TGT = 7'h1A;

  pullup (sda_bus);
  assign sda_bus = tb_rel ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .CLOCK   (clk),
    .RESET   (rst_n),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda_bus),
    .REG_ADDR(reg_addr),
    .REG_DATA(reg_data),
    .REG_WE  (reg_we),
    .BUSY    (busy),
    .ADDR_HIT(addr_hit)
  );

  // Strobe and stray-drive observers, sampled away from the active edge
  always @(negedge clk) begin
    if (reg_we) we_cycles++;
    if (reg_we && !we_prev) we_pulses++;
    we_prev = reg_we;
    if (tb_rel && sda_bus == 1'b0) spur_low++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period of 8 CLOCKs: data changes mid-low, sample mid-high
  task automatic send_bit(input logic b, output logic seen);
    wait_neg(2); tb_rel = b;
    wait_neg(2); scl = 1'b1;
    wait_neg(2); seen = sda_bus;
    wait_neg(2); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    acked = (s == 1'b0);
  endtask

  task automatic send_start;
    wait_neg(2); tb_rel = 1'b1;
    wait_neg(2); scl = 1'b1;
    wait_neg(2); tb_rel = 1'b0;
    wait_neg(4); scl = 1'b0;
  endtask

  task automatic send_stop;
    wait_neg(2); tb_rel = 1'b0;
    wait_neg(2); scl = 1'b1;
    wait_neg(2); tb_rel = 1'b1;
    wait_neg(6);
  endtask

  // Full transaction checked against the byte-list model
  task automatic run_txn(input string name, input logic [7:0] bytes[$]);
    bit hit;
    bit acked;
    bit exp_ack;
    int exp_we;
    int we0, wc0, sp0;
    hit    = (bytes.size() > 0) && (bytes[0][7:1] == TGT) && !bytes[0][0];
    exp_we = (hit && bytes.size() >= 3) ? 1 : 0;
    we0 = we_pulses; wc0 = we_cycles; sp0 = spur_low;
    send_start;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    else n_pass++;
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], acked);
      exp_ack = hit && (i < 3);
      n_checks++;
      if (acked != exp_ack) $display("FAIL %s ack_byte%0d: got %0d want %0d", name, i, acked, exp_ack);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (addr_hit !== hit) $display("FAIL %s addr_hit: got %b want %b", name, addr_hit, hit);
        else n_pass++;
      end
    end
    send_stop;
    if (exp_we == 1) begin
      exp_addr = bytes[1];
      exp_data = bytes[2];
    end
    n_checks++;
    if (we_pulses - we0 != exp_we || we_cycles - wc0 != exp_we)
      $display("FAIL %s reg_we: pulses %0d cycles %0d want %0d", name, we_pulses - we0, we_cycles - wc0, exp_we);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || addr_hit !== 1'b0)
      $display("FAIL %s idle_after_stop: busy %b hit %b want 0 0", name, busy, addr_hit);
    else n_pass++;
    n_checks++;
    if (reg_addr !== exp_addr || reg_data !== exp_data)
      $display("FAIL %s regs: got %h/%h want %h/%h", name, reg_addr, reg_data, exp_addr, exp_data);
    else n_pass++;
    if (!hit) begin
      n_checks++;
      if (spur_low != sp0) $display("FAIL %s sda_driven: got %0d low cycles want 0", name, spur_low - sp0);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; scl = 1'b1; tb_rel = 1'b1;
    wait_neg(4);
    n_checks++;
    if (reg_addr !== 8'h00 || reg_data !== 8'h00 || reg_we !== 1'b0 || busy !== 1'b0 || addr_hit !== 1'b0)
      $display("FAIL reset_outputs: got %h %h %b %b %b want 00 00 0 0 0", reg_addr, reg_data, reg_we, busy, addr_hit);
    else n_pass++;
    n_checks++;
    if (sda_bus !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda_bus);
    else n_pass++;
    rst_n = 1'b1;
    wait_neg(6);
  endtask

  task automatic test_full_write;
    logic [7:0] q[$];
    q = '{8'h34, 8'h07, 8'h4A};
    run_txn("full_write", q);
  endtask

  task automatic test_wrong_addr;
    logic [7:0] q[$];
    q = '{8'h36, 8'h11, 8'h22};
    run_txn("wrong_addr", q);
  endtask

  task automatic test_read_bit;
    logic [7:0] q[$];
    q = '{8'h35, 8'h12, 8'h34};
    run_txn("read_bit", q);
  endtask

  task automatic test_short;
    logic [7:0] q[$];
    q = '{8'h34, 8'h10};
    run_txn("short", q);
  endtask

  task automatic test_repeated_start;
    bit acked;
    logic s;
    logic [7:0] q[$];
    int we0;
    we0 = we_pulses;
    send_start;
    send_byte(8'h34, acked);
    n_checks++;
    if (!acked) $display("FAIL rstart_first_ack: got nack want ack");
    else n_pass++;
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b1, s);
    q = '{8'h34, 8'h02, 8'h99};
    run_txn("rstart_second", q);
    n_checks++;
    if (we_pulses - we0 != 1) $display("FAIL rstart_we_total: got %0d want 1", we_pulses - we0);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    int n;
    int sel;
    for (int t = 0; t < 10; t++) begin
      q.delete();
      n = $urandom_range(1, 5);
      sel = $urandom_range(0, 3);
      if (sel < 2) q.push_back(8'h34);
      else if (sel == 2) q.push_back(8'h35);
      else q.push_back(8'($urandom));
      for (int i = 1; i < n; i++) q.push_back(8'($urandom));
      run_txn($sformatf("random%0d", t), q);
    end
  endtask

  task automatic test_reset_mid;
    bit acked;
    logic s;
    logic [7:0] q[$];
    send_start;
    send_byte(8'h34, acked);
    for (int i = 7; i >= 0; i--) send_bit(i[0], s);
    wait_neg(2); tb_rel = 1'b1;
    wait_neg(2); scl = 1'b1;
    wait_neg(2);
    n_checks++;
    if (sda_bus !== 1'b0) $display("FAIL rmid_sub_ack_driven: got %b want 0", sda_bus);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sda_bus !== 1'b1) $display("FAIL rmid_sda_release: got %b want 1", sda_bus);
    else n_pass++;
    n_checks++;
    if (reg_addr !== 8'h00 || reg_data !== 8'h00 || reg_we !== 1'b0 || busy !== 1'b0 || addr_hit !== 1'b0)
      $display("FAIL rmid_outputs: got %h %h %b %b %b want 00 00 0 0 0", reg_addr, reg_data, reg_we, busy, addr_hit);
    else n_pass++;
    exp_addr = 8'h00;
    exp_data = 8'h00;
    wait_neg(4);
    rst_n = 1'b1;
    wait_neg(6);
    q = '{8'h34, 8'hC3, 8'h5E};
    run_txn("after_reset", q);
  endtask

  initial begin
    test_reset;
    test_full_write;
    test_wrong_addr;
    test_read_bit;
    test_short;
    test_repeated_start;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
